// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage (fixed priority)
// and one peripheral/DMA port, with a starvation-forced peripheral grant. Optional macro: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_io_req,
    input  logic              i_io_we,
    input  logic [ADDR_W-1:0] i_io_addr,
    input  logic [DATA_W-1:0] i_io_wdata,
    output logic              o_io_gnt,
    output logic [DATA_W-1:0] o_io_rdata,
    output logic              o_io_rvalid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       o_stat_conflicts,
    output logic [15:0]       o_stat_forced
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE,
        ST_RET
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_next;
    logic              r_io_rvalid;
    logic [DATA_W-1:0] r_io_rdata;
    logic              w_force;
    logic              w_grant_io;
    logic              w_grant_cpu;

    always_comb begin
        w_force     = i_io_req && (r_starve_cnt >= LIMIT);
        w_grant_io  = i_io_req && (!i_cpu_req || w_force);
        w_grant_cpu = i_cpu_req && !w_grant_io;

        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wren  = 1'b0;
        if (w_grant_io) begin
            o_mem_addr  = i_io_addr;
            o_mem_wdata = i_io_wdata;
            o_mem_wren  = i_io_we;
        end else if (w_grant_cpu) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
            o_mem_wren  = i_cpu_we;
        end

        o_cpu_stall = i_cpu_req && w_grant_io;
        o_io_gnt    = w_grant_io;
        o_cpu_rdata = i_mem_q;
    end

    // Count only while the peripheral keeps asking and keeps losing.
    always_comb begin
        w_starve_next = 4'd0;
        if (i_io_req && !w_grant_io) begin
            w_starve_next = (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;
        end
    end

    // ST_RET marks the cycle in which mem_q carries a peripheral read result.
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: if (w_grant_io && !i_io_we) w_state_next = ST_RET;
            ST_RET:  if (w_grant_io && !i_io_we) w_state_next = ST_RET;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_io_rvalid  <= 1'b0;
            r_io_rdata   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_io_rvalid  <= (r_state == ST_RET);
            if (r_state == ST_RET) begin
                r_io_rdata <= i_mem_q;
            end
        end
    end

    assign o_io_rvalid = r_io_rvalid;
    assign o_io_rdata  = r_io_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stat_conflicts;
    logic [15:0] r_stat_forced;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stat_conflicts <= 16'd0;
            r_stat_forced    <= 16'd0;
        end else begin
            if (i_cpu_req && i_io_req && (r_stat_conflicts != 16'hFFFF)) begin
                r_stat_conflicts <= r_stat_conflicts + 16'd1;
            end
            if (w_force && (r_stat_forced != 16'hFFFF)) begin
                r_stat_forced <= r_stat_forced + 16'd1;
            end
        end
    end

    assign o_stat_conflicts = r_stat_conflicts;
    assign o_stat_forced    = r_stat_forced;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration and read-return rules.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, io_req, io_we;
    logic [ADDR_W-1:0] cpu_addr, io_addr;
    logic [DATA_W-1:0] cpu_wdata, io_wdata;
    logic [DATA_W-1:0] cpu_rdata, io_rdata, mem_wdata, dmem_q;
    logic              cpu_stall, io_gnt, io_rvalid, mem_wren;
    logic [ADDR_W-1:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]       stat_conflicts, stat_forced;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_io_req(io_req), .i_io_we(io_we), .i_io_addr(io_addr), .i_io_wdata(io_wdata),
        .o_io_gnt(io_gnt), .o_io_rdata(io_rdata), .o_io_rvalid(io_rvalid),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren), .i_mem_q(dmem_q)
`ifdef DMEM_ARB_STATS_EN
        , .o_stat_conflicts(stat_conflicts), .o_stat_forced(stat_forced)
`endif
    );

    // Memory attached to the arbiter: single port, one-cycle synchronous read.
    logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_wren) dmem[mem_addr] <= mem_wdata;
        dmem_q <= dmem[mem_addr];
    end

    // Reference model state.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    ret_t              ret_q[$];
    int                m_cyc = 0;
    int                m_streak = 0;
    logic [DATA_W-1:0] m_last = '0;
    int                m_conflicts = 0;
    int                m_forced = 0;

    logic              exp_gnt, exp_stall, exp_wren, exp_rvalid, exp_force;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_rdata;

    int checks = 0;
    int errors = 0;

    task automatic model_eval();
        exp_force  = io_req && (m_streak >= LIMIT);
        exp_gnt    = io_req && (!cpu_req || exp_force);
        exp_stall  = cpu_req && exp_gnt;
        exp_wren   = 1'b0;
        exp_addr   = '0;
        exp_wdata  = '0;
        if (exp_gnt) begin
            exp_wren = io_we; exp_addr = io_addr; exp_wdata = io_wdata;
        end else if (cpu_req) begin
            exp_wren = cpu_we; exp_addr = cpu_addr; exp_wdata = cpu_wdata;
        end
        exp_rvalid = (ret_q.size() > 0) && (ret_q[0].due == m_cyc);
        exp_rdata  = exp_rvalid ? ret_q[0].data : m_last;
    endtask

    task automatic model_clock();
        ret_t r;
        if (exp_gnt && !io_we) begin
            r.due  = m_cyc + 2;
            r.data = ref_mem[io_addr];
            ret_q.push_back(r);
        end
        if (exp_wren) ref_mem[exp_addr] = exp_wdata;
        if (rst) begin
            ret_q.delete();
            m_last = '0; m_streak = 0; m_conflicts = 0; m_forced = 0;
        end else begin
            if (exp_rvalid) begin
                m_last = ret_q[0].data;
                void'(ret_q.pop_front());
            end
            if (!io_req || exp_gnt) m_streak = 0;
            else if (m_streak < 15) m_streak++;
            if (cpu_req && io_req && m_conflicts < 65535) m_conflicts++;
            if (exp_force && m_forced < 65535) m_forced++;
        end
        m_cyc++;
    endtask

    task automatic advance();
        model_eval();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        advance();
        rst = 0;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        advance();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        advance();
        advance();
        rst = 0;
        #1;
        checks++;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b want=0", io_rvalid); end
        checks++;
        if (io_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h want=0", io_rdata); end
        checks++;
        if (io_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_wren !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_idle_outputs got gnt=%b stall=%b wren=%b addr=%h wdata=%h want all 0",
                     io_gnt, cpu_stall, mem_wren, mem_addr, mem_wdata);
        end
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if (stat_conflicts !== 16'd0 || stat_forced !== 16'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_conflicts, stat_forced);
        end
`endif
        $display("txn reset done");
    endtask

    task automatic test_cpu_only();
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cpu_only_mem got wren=%b addr=%h wdata=%h want 1/010/deadbeef", mem_wren, mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_stall !== 1'b0 || io_gnt !== 1'b0) begin
            errors++; $display("FAIL cpu_only_ctrl got stall=%b gnt=%b want 0/0", cpu_stall, io_gnt);
        end
        advance();
        idle_inputs();
        $display("txn cpu write addr=010 data=deadbeef");
    endtask

    task automatic test_io_read();
        cpu_write(12'h020, 32'h12345678);
        io_req = 1; io_we = 0; io_addr = 12'h020;
        #1;
        checks++;
        if (io_gnt !== 1'b1 || mem_addr !== 12'h020 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL io_read_gnt got gnt=%b addr=%h wren=%b want 1/020/0", io_gnt, mem_addr, mem_wren);
        end
        advance();
        idle_inputs();
        #1;
        checks++;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL io_read_c1 got rvalid=%b want 0", io_rvalid); end
        advance();
        #1;
        checks++;
        if (io_rvalid !== 1'b1 || io_rdata !== 32'h12345678) begin
            errors++; $display("FAIL io_read_c2 got rvalid=%b rdata=%h want 1/12345678", io_rvalid, io_rdata);
        end
        advance();
        #1;
        checks++;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL io_read_c3 got rvalid=%b want 0", io_rvalid); end
        $display("txn io read addr=020 data=%h", io_rdata);
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 12'(k);
            io_req = 1; io_we = 1; io_addr = 12'h100; io_wdata = 32'(k);
            #1;
            checks++;
            if (io_gnt !== (k == 4 || k == 9) || cpu_stall !== (k == 4 || k == 9)) begin
                errors++;
                $display("FAIL contention_c%0d got gnt=%b stall=%b want %0d", k, io_gnt, cpu_stall, (k == 4 || k == 9));
            end
            advance();
        end
        idle_inputs();
        #1;
`ifdef DMEM_ARB_STATS_EN
        checks++;
        if (stat_conflicts !== 16'd10 || stat_forced !== 16'd2) begin
            errors++; $display("FAIL stats_contention got=%0d/%0d want=10/2", stat_conflicts, stat_forced);
        end
`endif
        $display("txn contention 10 cycles done");
    endtask

    task automatic test_back_to_back();
        cpu_write(12'h001, 32'h0000000A);
        cpu_write(12'h002, 32'h0000000B);
        io_req = 1; io_we = 0; io_addr = 12'h001;
        advance();
        io_addr = 12'h002;
        #1;
        checks++;
        if (io_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt2 got=%b want 1", io_gnt); end
        advance();
        idle_inputs();
        #1;
        checks++;
        if (io_rvalid !== 1'b1 || io_rdata !== 32'hA) begin
            errors++; $display("FAIL b2b_first got rvalid=%b rdata=%h want 1/a", io_rvalid, io_rdata);
        end
        advance();
        #1;
        checks++;
        if (io_rvalid !== 1'b1 || io_rdata !== 32'hB) begin
            errors++; $display("FAIL b2b_second got rvalid=%b rdata=%h want 1/b", io_rvalid, io_rdata);
        end
        advance();
        #1;
        checks++;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end got rvalid=%b want 0", io_rvalid); end
        $display("txn io back-to-back reads a,b");
    endtask

    task automatic test_reset_mid_return();
        io_req = 1; io_we = 0; io_addr = 12'h020;
        advance();
        idle_inputs();
        rst = 1;
        advance();
        rst = 0;
        #1;
        checks++;
        if (io_rvalid !== 1'b0 || io_rdata !== '0) begin
            errors++; $display("FAIL reset_mid_return got rvalid=%b rdata=%h want 0/0", io_rvalid, io_rdata);
        end
        advance();
        #1;
        checks++;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid_after got rvalid=%b want 0", io_rvalid); end
        // A cleared count means a contending peripheral waits the full limit again.
        for (int k = 0; k <= LIMIT; k++) begin
            cpu_req = 1; io_req = 1; io_we = 1; io_addr = 12'h200;
            #1;
            checks++;
            if (io_gnt !== (k == LIMIT)) begin
                errors++; $display("FAIL reset_starve_c%0d got gnt=%b want %0d", k, io_gnt, (k == LIMIT));
            end
            advance();
        end
        idle_inputs();
        $display("txn reset during read return");
    endtask

    task automatic test_random();
        do_reset();
        for (int a = 0; a < 16; a++) cpu_write(12'(a), $urandom);
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            cpu_req = $urandom_range(0, 1);
            cpu_we  = $urandom_range(0, 1);
            cpu_addr  = 12'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            if (!io_req || exp_gnt || $urandom_range(0, 29) == 0) begin
                io_req   = ($urandom_range(0, 2) != 0);
                io_we    = $urandom_range(0, 1);
                io_addr  = 12'($urandom_range(0, 15));
                io_wdata = $urandom;
            end
            #1;
            model_eval();
            checks++;
            if (io_gnt !== exp_gnt || cpu_stall !== exp_stall) begin
                errors++; $display("FAIL rnd_grant n=%0d got gnt=%b stall=%b want %b/%b", n, io_gnt, cpu_stall, exp_gnt, exp_stall);
            end
            checks++;
            if (mem_wren !== exp_wren || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL rnd_mem n=%0d got %b/%h/%h want %b/%h/%h", n, mem_wren, mem_addr, mem_wdata, exp_wren, exp_addr, exp_wdata);
            end
            checks++;
            if (io_rvalid !== exp_rvalid || io_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rnd_ret n=%0d got %b/%h want %b/%h", n, io_rvalid, io_rdata, exp_rvalid, exp_rdata);
            end
            checks++;
            if (cpu_rdata !== dmem_q) begin
                errors++; $display("FAIL rnd_cpu_rdata n=%0d got %h want %h", n, cpu_rdata, dmem_q);
            end
`ifdef DMEM_ARB_STATS_EN
            checks++;
            if (stat_conflicts !== 16'(m_conflicts) || stat_forced !== 16'(m_forced)) begin
                errors++;
                $display("FAIL rnd_stats n=%0d got %0d/%0d want %0d/%0d", n, stat_conflicts, stat_forced, m_conflicts, m_forced);
            end
`endif
            if (exp_gnt) $display("txn rnd io %s addr=%h stall=%b", io_we ? "wr" : "rd", io_addr, exp_stall);
            @(posedge clk);
            model_clock();
            @(negedge clk);
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_cpu_only();
        test_io_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_return();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the processor's memory stage and one peripheral/DMA requester on the IO side. CPU accesses have fixed priority. A starvation counter forces a peripheral grant after STARVE_LIMIT consecutive denied cycles, and the arbiter stalls the CPU for that cycle. The block sits between processor dmem outputs, the IO block and dmem in the wrapper.

Parameters:
ADDR_W, 12, dmem word-address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied io_req cycles before a forced peripheral grant (1..15)

Ports:
clock  in  1  master clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU memory-stage access valid (load or store)
cpu_we  in  1  CPU store
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  read data to CPU (mem_q passthrough)
cpu_stall  out  1  CPU must hold its memory-stage instruction this cycle
io_req  in  1  peripheral request; held until granted
io_we  in  1  peripheral write
io_addr  in  ADDR_W  peripheral word address
io_wdata  in  DATA_W  peripheral write data
io_gnt  out  1  one-cycle grant pulse; access happens this cycle
io_rdata  out  DATA_W  registered peripheral read data
io_rvalid  out  1  io_rdata valid, one cycle
mem_addr  out  ADDR_W  to dmem
mem_wdata  out  DATA_W  to dmem
mem_wren  out  1  to dmem
mem_q  in  DATA_W  dmem read data, 1-cycle synchronous read

Behaviour:
- Clock is clock. Reset is synchronous and active-high, sampled on the rising edge.
- Grant decision is combinational each cycle from the inputs and the registered starvation count (starve_cnt, 4 bits).
  - force = io_req && starve_cnt >= STARVE_LIMIT.
  - grant_io = io_req && (!cpu_req || force).
  - grant_cpu = cpu_req && !grant_io.
- mem_addr, mem_wdata and mem_wren come from the granted requester. With no grant: mem_addr = 0, mem_wdata = 0, mem_wren = 0.
- cpu_stall = cpu_req && grant_io. This is only possible under force.
- io_gnt = grant_io.
- starve_cnt update each cycle:
  - cleared on grant_io or when !io_req;
  - incremented (saturating at 15) when io_req && !grant_io.
- Read return:
  - the rd_io flag registers grant_io && !io_we;
  - next cycle io_rvalid = rd_io and io_rdata <= mem_q, registered one more cycle: io_rdata is valid in the cycle io_rvalid is high.
  - Total io read latency is 2 cycles from io_gnt.
- cpu_rdata = mem_q unconditionally. The CPU pipeline already absorbs the 1-cycle dmem latency.
- Writes complete in the grant cycle. io_rvalid never asserts for a write.
- Simultaneous cpu_req and io_req with starve_cnt < STARVE_LIMIT: CPU wins, count increments.
- io_req dropped before grant: count clears and no grant is issued. Protocol violation, but it must not hang.
- Back-to-back forced grants are impossible: the count clears on grant, so the CPU gets at least STARVE_LIMIT cycles between forced stalls.
- Reset values, including reset mid-operation: starve_cnt = 0, rd_io = 0, io_rvalid = 0, io_rdata = 0. Any pending read return is discarded. Combinational outputs follow their inputs immediately after reset.
- Two-state FSM on rd_io:
  - IDLE -> RET when a peripheral read is granted;
  - RET -> RET on a back-to-back peripheral read grant, otherwise RET -> IDLE.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds output stat_conflicts (16 bits) and output stat_forced (16 bits), both saturating counters cleared by reset.
  - stat_conflicts increments on every cycle with cpu_req && io_req.
  - stat_forced increments on every forced grant.
- Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr 0x010, wdata 0xDEADBEEF -> mem_wren=1, mem_addr=0x010, cpu_stall=0, io_gnt=0.
- IO read uncontended: io_req=1, io_we=0, addr 0x020, dmem holds 0x12345678 -> io_gnt in cycle 0, io_rvalid=1 and io_rdata=0x12345678 in cycle 2.
- Contention with STARVE_LIMIT=4: cpu_req and io_req high continuously -> CPU granted cycles 0-3, cycle 4 io_gnt=1 and cpu_stall=1, CPU granted cycles 5-8, forced grant again at cycle 9.
- Back-to-back IO reads at addrs 1, 2 (values 0xA, 0xB), no CPU -> io_rvalid high two consecutive cycles with io_rdata 0xA then 0xB.
- Reset mid-return: reset asserted the cycle after an IO read grant -> io_rvalid=0, io_rdata=0, starve_cnt=0 on the next edge.
- DMEM_ARB_STATS_EN defined with the contention scenario for 10 cycles -> stat_conflicts=10, stat_forced=2.
